llc_req_arbiter: RTL and testbench

Parametrised LLC input front-end that selects one message per cycle from a coherence-response channel, a single-entry parked-request replay slot and `NUM_REQ` request channels, then presents it to the LLC pipeline through a registered valid/ready output stage. It generalises the fixed rsp/req/dma decode priority to N request channels with round-robin fairness and per-set blocking. It also adds replay of a request that the pipeline parks because its set is busy.

---
 rtl/llc_req_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_llc_req_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/llc_req_arbiter.sv
// LLC input front-end: picks one of rsp / parked replay / N round-robin request
// channels per cycle and holds it in a single registered valid/ready output entry.
module llc_req_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 28,
  parameter int SET_W     = 9,
  parameter int PAYLOAD_W = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rsp_valid,
  output logic                         rsp_ready,
  input  logic [ADDR_W-1:0]            rsp_addr,
  input  logic [PAYLOAD_W-1:0]         rsp_payload,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*PAYLOAD_W-1:0] req_payload,
  input  logic                         park_valid,
  output logic                         park_ready,
  input  logic [ADDR_W-1:0]            park_addr,
  input  logic [PAYLOAD_W-1:0]         park_payload,
  input  logic [2:0]                   park_chan,
  input  logic                         block_valid,
  input  logic [SET_W-1:0]             block_set,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [1:0]                   out_kind,
  output logic [2:0]                   out_chan,
  output logic [ADDR_W-1:0]            out_addr,
  output logic [PAYLOAD_W-1:0]         out_payload,
  output logic                         parked,
  output logic [15:0]                  blocked_cycles
);

  localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {KIND_RSP = 2'd0, KIND_REQ = 2'd1, KIND_RPL = 2'd2} kind_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [RR_W-1:0] rr_add(input logic [RR_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return RR_W'(s);
  endfunction

  function automatic logic [RR_W-1:0] rr_next(input logic [RR_W-1:0] g);
    if ((NUM_REQ == 1) || (int'(g) == NUM_REQ - 1)) return '0;
    return g + 1'b1;
  endfunction

  logic                 r_out_valid_p1;
  kind_e                r_out_kind_p1;
  logic [2:0]           r_out_chan_p1;
  logic [ADDR_W-1:0]    r_out_addr_p1;
  logic [PAYLOAD_W-1:0] r_out_payload_p1;
  logic                 r_parked;
  logic [ADDR_W-1:0]    r_park_addr;
  logic [PAYLOAD_W-1:0] r_park_payload;
  logic [2:0]           r_park_chan;
  logic [RR_W-1:0]      r_rr;
  logic [15:0]          r_blocked_cycles;

  logic [ADDR_W-1:0]    w_req_addr_a [NUM_REQ];
  logic [PAYLOAD_W-1:0] w_req_pay_a  [NUM_REQ];
  logic [NUM_REQ-1:0]   w_req_blk;
  logic [NUM_REQ-1:0]   w_req_elig;
  logic                 w_slot_free;
  logic                 w_park_blk;
  logic                 w_req_hit;
  logic [RR_W-1:0]      w_req_idx;
  logic                 w_gnt_rsp;
  logic                 w_gnt_rpl;
  logic                 w_gnt_req;
  logic                 w_gnt_any;
  logic                 w_any_blk;
  kind_e                w_kind;
  logic [2:0]           w_chan;
  logic [ADDR_W-1:0]    w_addr;
  logic [PAYLOAD_W-1:0] w_payload;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_req_addr_a[gi] = req_addr[gi*ADDR_W +: ADDR_W];
    assign w_req_pay_a[gi]  = req_payload[gi*PAYLOAD_W +: PAYLOAD_W];
    assign w_req_blk[gi]    = block_valid && (w_req_addr_a[gi][SET_W-1:0] == block_set);
  end

  // A pending park holds back all new requests so they stay ordered behind it.
  assign w_req_elig  = req_valid & ~w_req_blk & {NUM_REQ{!r_parked}};
  assign w_slot_free = !r_out_valid_p1 || out_ready;
  assign w_park_blk  = block_valid && (r_park_addr[SET_W-1:0] == block_set);
  assign w_any_blk   = (|(req_valid & w_req_blk)) || (r_parked && w_park_blk);

  always_comb begin
    w_req_hit = 1'b0;
    w_req_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_req_hit && w_req_elig[rr_add(r_rr, k)]) begin
        w_req_hit = 1'b1;
        w_req_idx = rr_add(r_rr, k);
      end
    end
  end

  assign w_gnt_rsp = w_slot_free && rsp_valid;
  assign w_gnt_rpl = w_slot_free && !rsp_valid && r_parked && !w_park_blk;
  assign w_gnt_req = w_slot_free && !rsp_valid && w_req_hit;
  assign w_gnt_any = w_gnt_rsp || w_gnt_rpl || w_gnt_req;

  always_comb begin
    w_kind    = KIND_RSP;
    w_chan    = 3'd0;
    w_addr    = rsp_addr;
    w_payload = rsp_payload;
    if (w_gnt_rpl) begin
      w_kind    = KIND_RPL;
      w_chan    = r_park_chan;
      w_addr    = r_park_addr;
      w_payload = r_park_payload;
    end else if (w_gnt_req) begin
      w_kind    = KIND_REQ;
      w_chan    = 3'(w_req_idx);
      w_addr    = w_req_addr_a[w_req_idx];
      w_payload = w_req_pay_a[w_req_idx];
    end
  end

  assign rsp_ready  = rst && w_gnt_rsp;
  assign req_ready  = (rst && w_gnt_req) ? (NUM_REQ'(1) << w_req_idx) : '0;
  assign park_ready = rst && !r_parked;

  // Stage p1: registered output entry plus arbitration/park control state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid_p1   <= 1'b0;
      r_out_kind_p1    <= KIND_RSP;
      r_out_chan_p1    <= 3'd0;
      r_out_addr_p1    <= '0;
      r_out_payload_p1 <= '0;
      r_parked         <= 1'b0;
      r_rr             <= '0;
      r_blocked_cycles <= 16'd0;
    end else begin
      if (w_slot_free) begin
        r_out_valid_p1 <= w_gnt_any;
        if (w_gnt_any) begin
          r_out_kind_p1    <= w_kind;
          r_out_chan_p1    <= w_chan;
          r_out_addr_p1    <= w_addr;
          r_out_payload_p1 <= w_payload;
        end
      end
      if (w_gnt_req) r_rr <= rr_next(w_req_idx);
      if (w_gnt_rpl) r_parked <= 1'b0;
      else if (park_valid && !r_parked) r_parked <= 1'b1;
      if (w_any_blk) r_blocked_cycles <= sat_inc16(r_blocked_cycles);
    end
  end

  always_ff @(posedge clk) begin
    if (park_valid && !r_parked) begin
      r_park_addr    <= park_addr;
      r_park_payload <= park_payload;
      r_park_chan    <= park_chan;
    end
  end

  assign out_valid      = r_out_valid_p1;
  assign out_kind       = r_out_kind_p1;
  assign out_chan       = r_out_chan_p1;
  assign out_addr       = r_out_addr_p1;
  assign out_payload    = r_out_payload_p1;
  assign parked         = r_parked;
  assign blocked_cycles = r_blocked_cycles;

endmodule

// File: tb/tb_llc_req_arbiter.sv
// Scoreboard bench for llc_req_arbiter: directed scenarios plus random traffic
// checked against a transaction-level reference model.
module tb_llc_req_arbiter;
  localparam int N  = 3;
  localparam int AW = 28;
  localparam int SW = 9;
  localparam int PW = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            rsp_valid, rsp_ready;
  logic [AW-1:0]   rsp_addr;
  logic [PW-1:0]   rsp_payload;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*PW-1:0] req_payload;
  logic            park_valid, park_ready;
  logic [AW-1:0]   park_addr;
  logic [PW-1:0]   park_payload;
  logic [2:0]      park_chan;
  logic            block_valid;
  logic [SW-1:0]   block_set;
  logic            out_valid, out_ready;
  logic [1:0]      out_kind;
  logic [2:0]      out_chan;
  logic [AW-1:0]   out_addr;
  logic [PW-1:0]   out_payload;
  logic            parked;
  logic [15:0]     blocked_cycles;

  llc_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .SET_W(SW), .PAYLOAD_W(PW)) dut (
    .clk(clk), .rst(rst),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_payload(rsp_payload),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_payload(req_payload),
    .park_valid(park_valid), .park_ready(park_ready), .park_addr(park_addr),
    .park_payload(park_payload), .park_chan(park_chan),
    .block_valid(block_valid), .block_set(block_set),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind), .out_chan(out_chan),
    .out_addr(out_addr), .out_payload(out_payload),
    .parked(parked), .blocked_cycles(blocked_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            kind;
    int            chan;
    logic [AW-1:0] addr;
    logic [PW-1:0] pay;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state (post-edge view of the DUT)
  bit            m_ov;
  bit            m_parked;
  logic [AW-1:0] m_paddr;
  logic [PW-1:0] m_ppay;
  int            m_pchan;
  int            m_rr;
  int            m_bc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit blk(input logic [AW-1:0] a);
    return block_valid && (a[SW-1:0] == block_set);
  endfunction

  function automatic logic [AW-1:0] raddr(input int c);
    return req_addr[c*AW +: AW];
  endfunction

  function automatic logic [AW-1:0] mkaddr(input int set);
    logic [AW-1:0] a;
    a = AW'($urandom);
    a[SW-1:0] = SW'(set);
    return a;
  endfunction

  function automatic int rand_set();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511)) : 5 + int'($urandom_range(0, 2));
  endfunction

  task automatic model_reset();
    m_ov = 0; m_parked = 0; m_rr = 0; m_bc = 0; m_pchan = 0;
    m_paddr = '0; m_ppay = '0;
    q.delete();
  endtask

  task automatic quiet_inputs();
    rsp_valid = 0; req_valid = '0; park_valid = 0; block_valid = 0; block_set = '0;
    out_ready = 1;
  endtask

  // One cycle: check state + readies at negedge, then advance the model at the edge.
  task automatic step();
    bit sf, any_blk;
    int gk, gc;
    logic [N-1:0] exp_rdy;
    exp_t e;
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("parked", 64'(parked), 64'(m_parked));
    chk("blocked_cycles", 64'(blocked_cycles), 64'(m_bc));
    sf = !m_ov || out_ready;
    gk = -1; gc = 0;
    if (sf) begin
      if (rsp_valid) gk = 0;
      else if (m_parked && !blk(m_paddr)) begin gk = 2; gc = m_pchan; end
      else if (!m_parked) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_rr + k) % N;
          if (req_valid[c] && !blk(raddr(c))) begin gk = 1; gc = c; break; end
        end
      end
    end
    any_blk = m_parked && blk(m_paddr);
    for (int i = 0; i < N; i++) if (req_valid[i] && blk(raddr(i))) any_blk = 1;
    exp_rdy = (gk == 1) ? N'(1 << gc) : '0;
    chk("rsp_ready", 64'(rsp_ready), 64'(gk == 0));
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("park_ready", 64'(park_ready), 64'(!m_parked));
    if (gk >= 0) begin
      e.kind = gk; e.chan = gc;
      if (gk == 0) begin e.addr = rsp_addr; e.pay = rsp_payload; e.chan = 0; end
      else if (gk == 2) begin e.addr = m_paddr; e.pay = m_ppay; end
      else begin e.addr = raddr(gc); e.pay = req_payload[gc*PW +: PW]; end
      q.push_back(e);
    end
    @(posedge clk);
    if (gk == 2) m_parked = 0;
    else if (park_valid && !m_parked) begin
      m_parked = 1; m_paddr = park_addr; m_ppay = park_payload; m_pchan = int'(park_chan);
    end
    if (any_blk && m_bc != 16'hFFFF) m_bc++;
    if (sf) m_ov = (gk >= 0);
    if (gk == 1) m_rr = (gc + 1) % N;
    #1;
  endtask

  task automatic rand_inputs();
    rsp_valid = ($urandom_range(0, 3) == 0);
    rsp_addr = mkaddr(rand_set());
    rsp_payload = {$urandom, $urandom};
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'($urandom_range(0, 1));
      req_addr[i*AW +: AW] = mkaddr(rand_set());
      req_payload[i*PW +: PW] = {$urandom, $urandom};
    end
    park_valid = ($urandom_range(0, 7) == 0);
    park_addr = mkaddr(rand_set());
    park_payload = {$urandom, $urandom};
    park_chan = 3'($urandom_range(0, 2));
    block_valid = ($urandom_range(0, 2) == 0);
    block_set = SW'(5 + $urandom_range(0, 2));
    out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Monitor: compare the presented output entry against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && out_valid) begin
        if (q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL out_unexpected: got out_valid 1 kind %0d expected no entry at %0t", out_kind, $time);
        end else begin
          e = q[0];
          chk("out_kind", 64'(out_kind), 64'(e.kind));
          chk("out_chan", 64'(out_chan), 64'(e.chan));
          chk("out_addr", 64'(out_addr), 64'(e.addr));
          chk("out_payload", out_payload, e.pay);
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    quiet_inputs();
    rsp_addr = '0; rsp_payload = '0; req_addr = '0; req_payload = '0;
    park_addr = '0; park_payload = '0; park_chan = '0;
    rsp_valid = 1; req_valid = '1; park_valid = 1;
    model_reset();
    #2;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_kind", 64'(out_kind), 0);
    chk("rst_out_chan", 64'(out_chan), 0);
    chk("rst_out_addr", 64'(out_addr), 0);
    chk("rst_out_payload", out_payload, 0);
    chk("rst_parked", 64'(parked), 0);
    chk("rst_blocked", 64'(blocked_cycles), 0);
    chk("rst_rsp_ready", 64'(rsp_ready), 0);
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_park_ready", 64'(park_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    quiet_inputs();
    rst = 1;

    // Round-robin with all channels requesting
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = mkaddr(i + 1);
      req_payload[i*PW +: PW] = {$urandom, $urandom};
    end
    req_valid = '1;
    repeat (7) step();
    req_valid = '0;
    step();

    // Response beats a request; rr untouched
    rsp_valid = 1; rsp_addr = mkaddr(9); rsp_payload = {$urandom, $urandom};
    req_valid = 3'b001;
    step();
    rsp_valid = 0;
    repeat (2) step();
    req_valid = '0;

    // Set block on set 5
    block_valid = 1; block_set = 9'h05;
    req_addr[0*AW +: AW] = mkaddr(5);
    req_addr[1*AW +: AW] = mkaddr(6);
    req_valid = 3'b011;
    repeat (4) step();
    block_valid = 0;
    repeat (2) step();
    req_valid = '0;
    step();

    // Park on a blocked set, then replay after unblock
    block_valid = 1; block_set = 9'h05;
    park_valid = 1; park_addr = mkaddr(5); park_chan = 3'd1; park_payload = {$urandom, $urandom};
    req_addr[0*AW +: AW] = mkaddr(7);
    req_valid = 3'b001;
    step();
    park_valid = 0;
    repeat (3) step();
    block_valid = 0;
    repeat (3) step();
    req_valid = '0;

    // Backpressure with everything valid
    rsp_valid = 1; req_valid = '1; out_ready = 0;
    step();
    repeat (4) step();
    out_ready = 1;
    repeat (2) step();
    rsp_valid = 0; req_valid = '0;
    repeat (3) step();

    repeat (3000) begin
      rand_inputs();
      step();
    end

    // Async reset with a live output entry and an occupied park slot
    quiet_inputs();
    block_valid = 1; block_set = 9'h05;
    park_valid = 1; park_addr = mkaddr(5); park_chan = 3'd2;
    rsp_valid = 1; rsp_addr = mkaddr(8);
    step();
    park_valid = 0; out_ready = 0;
    step();
    chk("pre_rst_out_valid", 64'(out_valid), 1);
    chk("pre_rst_parked", 64'(parked), 1);
    rst = 0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 0);
    chk("arst_parked", 64'(parked), 0);
    chk("arst_blocked", 64'(blocked_cycles), 0);
    chk("arst_rr", 64'(dut.r_rr), 0);
    chk("arst_rsp_ready", 64'(rsp_ready), 0);
    model_reset();
    quiet_inputs();
    @(posedge clk);
    #1;
    rst = 1;

    repeat (500) begin
      rand_inputs();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
